imem_boot_loader: RTL and testbench

//  Upstream of the pipelined CPU. Receives a byte stream (valid/ready) and assembles

---
 rtl/imem_boot_loader_pkg.sv | 25 ++
 rtl/imem_boot_loader_if.sv | 36 +++
 rtl/imem_boot_loader_word_assembler.sv | 45 ++++
 rtl/imem_boot_loader.sv | 159 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the CHECK state and the running sum).
package imem_boot_loader_pkg;

    localparam int unsigned BOOT_ADDR_W     = 6;
    localparam int unsigned BOOT_MAX_WORDS  = 64;
    localparam logic [7:0]  BOOT_DEFAULT_PC = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_LOADPC,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

    // A length byte is usable when it is non-zero and fits in the IMEM image window.
    function automatic logic len_ok(input logic [7:0] n, input int unsigned max_words);
        return (n != 8'd0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot-loader bus bundle: byte stream in, IMEM write port and CPU control out.
//   master : the loader (drives ready, IMEM write, hold/pc_load and status)
//   slave  : the environment (drives start and the byte stream)
interface imem_boot_loader_if
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = BOOT_ADDR_W
) ();

    logic              BL_start;
    logic              BL_byte_valid;
    logic [7:0]        BL_byte_data;
    logic              BL_byte_ready;
    logic              BL_imem_we;
    logic [ADDR_W-1:0] BL_imem_addr;
    logic [31:0]       BL_imem_data;
    logic              BL_cpu_hold;
    logic              BL_pc_load;
    logic [7:0]        BL_pc_val;
    logic              BL_busy;
    logic              BL_done;
    logic              BL_error;

    modport master (
        input  BL_start, BL_byte_valid, BL_byte_data,
        output BL_byte_ready, BL_imem_we, BL_imem_addr, BL_imem_data,
               BL_cpu_hold, BL_pc_load, BL_pc_val, BL_busy, BL_done, BL_error
    );

    modport slave (
        output BL_start, BL_byte_valid, BL_byte_data,
        input  BL_byte_ready, BL_imem_we, BL_imem_addr, BL_imem_data,
               BL_cpu_hold, BL_pc_load, BL_pc_val, BL_busy, BL_done, BL_error
    );

endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
//   clk, rst        : clock, synchronous active-high reset
//   i_clear         : restart the byte count and drop word_ready
//   i_byte_en       : insert i_byte at the current byte lane
//   o_word          : assembled word (registered)
//   o_word_ready    : high for the cycle after the 4th byte until cleared
//   o_last_byte_c   : next accepted byte completes the word
module imem_boot_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready,
    output logic        o_last_byte_c
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_word_ready;

    // Byte k lands in bits [8k+7:8k]; the lane index is the byte count times eight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 2'd0;
            r_word       <= 32'd0;
            r_word_ready <= 1'b0;
        end else if (i_clear) begin
            r_cnt        <= 2'd0;
            r_word_ready <= 1'b0;
        end else if (i_byte_en) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
            r_cnt                        <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_word_ready <= 1'b1;
            end
        end
    end

    assign o_word        = r_word;
    assign o_word_ready  = r_word_ready;
    assign o_last_byte_c = (r_cnt == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: takes a length-prefixed byte stream, writes the
// image into IMEM at word addresses 0..N-1, then pulses the CPU PC-load path and
// releases the CPU hold.
//   SYS_clk, SYS_reset : clock, synchronous active-high reset
//   bl (master)        : start/byte stream in; ready, IMEM write, hold, pc_load,
//                        pc_val, busy, done, error out (all registered)
// Optional feature macro: BOOT_CHECKSUM_EN -- one trailing byte must equal the
// mod-256 sum of the data bytes before the PC is loaded.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = BOOT_ADDR_W,
    parameter int unsigned MAX_WORDS = BOOT_MAX_WORDS,
    parameter logic [7:0]  BOOT_PC   = BOOT_DEFAULT_PC
) (
    input  logic                SYS_clk,
    input  logic                SYS_reset,
    imem_boot_loader_if.master  bl
);

    boot_state_e       r_state;
    boot_state_e       w_next;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_last;
    logic              r_ready;
    logic              r_hold;
    logic              r_pc_load;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [7:0]        r_pc_val;
    logic              w_accept;
    logic              w_asm_en;
    logic              w_asm_clr;
    logic [31:0]       w_word;
    logic              w_word_ready;
    logic              w_last_byte;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    assign w_accept  = bl.BL_byte_valid && r_ready;
    assign w_asm_en  = (r_state == ST_DATA) && w_accept;
    assign w_asm_clr = (r_state == ST_WRITE) || (r_state == ST_LEN);

    imem_boot_loader_word_assembler u_asm (
        .clk           (SYS_clk),
        .rst           (SYS_reset),
        .i_clear       (w_asm_clr),
        .i_byte_en     (w_asm_en),
        .i_byte        (bl.BL_byte_data),
        .o_word        (w_word),
        .o_word_ready  (w_word_ready),
        .o_last_byte_c (w_last_byte)
    );

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bl.BL_start) w_next = ST_LEN;
            end
            ST_LEN: begin
                if (w_accept) begin
                    w_next = len_ok(bl.BL_byte_data, MAX_WORDS) ? ST_DATA : ST_ERROR;
                end
            end
            ST_DATA: begin
                if (w_accept && w_last_byte) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_index == r_last) begin
`ifdef BOOT_CHECKSUM_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_LOADPC;
`endif
                end else begin
                    w_next = ST_DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    w_next = (bl.BL_byte_data == r_sum) ? ST_LOADPC : ST_ERROR;
                end
            end
`endif
            ST_LOADPC: w_next = ST_DONE;
            ST_DONE, ST_ERROR: begin
                if (bl.BL_start) w_next = ST_LEN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and outputs decoded from the upcoming state, so they line up with it.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b0;
            r_hold    <= 1'b0;
            r_pc_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_pc_val  <= BOOT_PC;
        end else begin
            r_state   <= w_next;
            r_ready   <= w_next inside {ST_LEN, ST_DATA, ST_CHECK};
            r_busy    <= w_next inside {ST_LEN, ST_DATA, ST_WRITE, ST_CHECK, ST_LOADPC};
            r_hold    <= w_next inside {ST_LEN, ST_DATA, ST_WRITE, ST_CHECK, ST_LOADPC, ST_ERROR};
            r_pc_load <= (w_next == ST_LOADPC);
            r_done    <= (w_next == ST_DONE);
            r_error   <= (w_next == ST_ERROR);
            r_pc_val  <= BOOT_PC;
        end
    end

    // Word index and last index; the index stops at N-1 so it never wraps.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_index <= '0;
            r_last  <= '0;
        end else if ((r_state == ST_LEN) && w_accept) begin
            r_index <= '0;
            r_last  <= ADDR_W'(bl.BL_byte_data - 8'd1);
        end else if ((r_state == ST_WRITE) && (r_index != r_last)) begin
            r_index <= r_index + ADDR_W'(1);
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running mod-256 sum of data bytes only.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_sum <= 8'd0;
        end else if ((r_state == ST_LEN) && w_accept) begin
            r_sum <= 8'd0;
        end else if (w_asm_en) begin
            r_sum <= r_sum + bl.BL_byte_data;
        end
    end
`endif

    // The assembler's word_ready is high exactly during WRITE, so it is the write strobe.
    assign bl.BL_byte_ready = r_ready;
    assign bl.BL_imem_we    = w_word_ready;
    assign bl.BL_imem_addr  = r_index;
    assign bl.BL_imem_data  = w_word;
    assign bl.BL_cpu_hold   = r_hold;
    assign bl.BL_pc_load    = r_pc_load;
    assign bl.BL_pc_val     = r_pc_val;
    assign bl.BL_busy       = r_busy;
    assign bl.BL_done       = r_done;
    assign bl.BL_error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected IMEM writes and
// PC loads into a queue; a negedge monitor pops and compares them as they appear.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int unsigned ADDR_W = 6;

    typedef struct packed {
        logic        is_pc;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic SYS_clk = 1'b0;
    logic SYS_reset;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bl ();

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(64), .BOOT_PC(8'h00)) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .bl        (bl)
    );

    always #5 SYS_clk = ~SYS_clk;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] img [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected no such event", name, act);
    endtask

    // Monitor: every write / PC load must match the head of the expectation queue.
    always @(negedge SYS_clk) begin
        if (!SYS_reset) begin
            if (bl.BL_imem_we) begin
                check("ready_low_in_write", 32'(bl.BL_byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    fail("unexpected_write", 32'(bl.BL_imem_addr));
                end else begin
                    m_e = exp_q.pop_front();
                    check("event_is_write", 32'(m_e.is_pc), 32'd0);
                    check("write_addr", 32'(bl.BL_imem_addr), 32'(m_e.addr));
                    check("write_data", bl.BL_imem_data, m_e.data);
                end
            end
            if (bl.BL_pc_load) begin
                check("hold_at_pc_load", 32'(bl.BL_cpu_hold), 32'd1);
                if (exp_q.size() == 0) begin
                    fail("unexpected_pc_load", 32'(bl.BL_pc_val));
                end else begin
                    m_e = exp_q.pop_front();
                    check("event_is_pc_load", 32'(m_e.is_pc), 32'd1);
                    check("pc_val", 32'(bl.BL_pc_val), 32'h00);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   32'(bl.BL_byte_ready), 32'd0);
        check({tag, "_we"},      32'(bl.BL_imem_we),    32'd0);
        check({tag, "_hold"},    32'(bl.BL_cpu_hold),   32'd0);
        check({tag, "_pc_load"}, 32'(bl.BL_pc_load),    32'd0);
        check({tag, "_busy"},    32'(bl.BL_busy),       32'd0);
        check({tag, "_done"},    32'(bl.BL_done),       32'd0);
        check({tag, "_error"},   32'(bl.BL_error),      32'd0);
        check({tag, "_addr"},    32'(bl.BL_imem_addr),  32'd0);
        check({tag, "_data"},    bl.BL_imem_data,       32'd0);
        check({tag, "_pc_val"},  32'(bl.BL_pc_val),     32'h00);
    endtask

    task automatic pulse_start();
        bl.BL_start = 1'b1;
        @(negedge SYS_clk);
        bl.BL_start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            bl.BL_byte_valid = 1'b0;
            @(negedge SYS_clk);
        end
        bl.BL_byte_valid = 1'b1;
        bl.BL_byte_data  = b;
        t = 0;
        while (!bl.BL_byte_ready && t < 100) begin
            @(negedge SYS_clk);
            t++;
        end
        if (!bl.BL_byte_ready) fail("byte_accept_timeout", 32'(b));
        @(negedge SYS_clk);
    endtask

    // Sends length + first n words of img (+ checksum when enabled) and queues expectations.
    task automatic send_image(input int n, input bit gaps, input bit expect_pc, input bit hold_valid);
        logic [7:0]  sum;
        logic [31:0] w;
        sum = 8'd0;
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 6'(i), img[i]});
        if (expect_pc) exp_q.push_back({1'b1, 6'd0, 32'd0});
        pulse_start();
        send_byte(8'(n), 0);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                sum = sum + 8'(w >> (8 * k));
                send_byte(8'(w >> (8 * k)), gaps ? int'($urandom_range(0, 3)) : 0);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(sum, 0);
`endif
        if (!hold_valid) bl.BL_byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input bit exp_done);
        int t;
        t = 0;
        while (!(bl.BL_done || bl.BL_error) && t < 200) begin
            @(negedge SYS_clk);
            t++;
        end
        check({name, "_done"},  32'(bl.BL_done),       32'(exp_done));
        check({name, "_error"}, 32'(bl.BL_error),      32'(!exp_done));
        check({name, "_hold"},  32'(bl.BL_cpu_hold),   32'(!exp_done));
        check({name, "_busy"},  32'(bl.BL_busy),       32'd0);
        check({name, "_ready"}, 32'(bl.BL_byte_ready), 32'd0);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        SYS_reset        = 1'b1;
        bl.BL_start      = 1'b0;
        bl.BL_byte_valid = 1'b0;
        bl.BL_byte_data  = 8'h00;
        repeat (3) @(negedge SYS_clk);
        SYS_reset = 1'b0;
        check_reset_outputs("reset");

        // 1: single word 20 00 08 20 -> 0x20080020
        img[0] = 32'h2008_0020;
        send_image(1, 1'b0, 1'b1, 1'b0);
        wait_end("one_word", 1'b1);

        // 2: maximum image of 64 words
        for (int i = 0; i < 64; i++) begin
            img[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
        end
        send_image(64, 1'b0, 1'b1, 1'b0);
        wait_end("max_image", 1'b1);

        // 3: bad lengths 0 and 65, then recovery
        pulse_start();
        send_byte(8'h00, 0);
        bl.BL_byte_valid = 1'b0;
        wait_end("len_zero", 1'b0);
        pulse_start();
        send_byte(8'h41, 0);
        bl.BL_byte_valid = 1'b0;
        wait_end("len_65", 1'b0);
        img[0] = 32'hCAFE_F00D;
        send_image(1, 1'b0, 1'b1, 1'b0);
        wait_end("recover", 1'b1);

        // 4: gaps between bytes, valid kept high past the last byte
        img[0] = 32'hDEAD_BEEF;
        img[1] = 32'h0123_4567;
        img[2] = 32'h89AB_CDEF;
        send_image(3, 1'b1, 1'b1, 1'b1);
        bl.BL_byte_data = 8'hEE;
        repeat (6) @(negedge SYS_clk);
        bl.BL_byte_valid = 1'b0;
        wait_end("gaps", 1'b1);

        // 5: reset after 2 of 3 words, then restart from address 0
        img[0] = 32'h1111_1111;
        img[1] = 32'h2222_2222;
        img[2] = 32'h3333_3333;
        exp_q.push_back({1'b0, 6'd0, img[0]});
        exp_q.push_back({1'b0, 6'd1, img[1]});
        pulse_start();
        send_byte(8'd3, 0);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(img[i] >> (8 * k)), 0);
        end
        bl.BL_byte_valid = 1'b0;
        @(negedge SYS_clk);
        SYS_reset = 1'b1;
        @(negedge SYS_clk);
        SYS_reset = 1'b0;
        check_reset_outputs("mid_reset");
        check("mid_reset_queue", 32'(exp_q.size()), 32'd0);
        send_image(3, 1'b0, 1'b1, 1'b0);
        wait_end("restart", 1'b1);

`ifdef BOOT_CHECKSUM_EN
        // 6: checksum 0x0A accepted, 0x0B rejected
        exp_q.push_back({1'b0, 6'd0, 32'h0403_0201});
        exp_q.push_back({1'b1, 6'd0, 32'd0});
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h0A, 0);
        bl.BL_byte_valid = 1'b0;
        wait_end("csum_good", 1'b1);
        exp_q.push_back({1'b0, 6'd0, 32'h0403_0201});
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h0B, 0);
        bl.BL_byte_valid = 1'b0;
        wait_end("csum_bad", 1'b0);
`endif

        repeat (4) @(negedge SYS_clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
